cdb_arbiter: RTL and testbench

- Shares the N_WAY-wide common data bus (CDB) among the functional-unit result ports of the execute stage.
- Each cycle it grants up to N_CDB of N_REQ pending completions, using a rotating round-robin priority.
- It registers the winners onto the CDB. The CDB tags drive the ROB complete, reservation-station wakeup and map-table ready-bit paths.
- Losing requesters hold their result and are back-pressured through grant.

---
 rtl/cdb_arbiter_pkg.sv | 27 ++
 rtl/cdb_arbiter_rr_select_n.sv | 39 +++
 rtl/cdb_arbiter.sv | 102 ++++++++++
 tb/tb_cdb_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and sizing constants for the execute-stage completion path.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif

package cdb_arbiter_pkg;

    localparam int N_CDB    = `N_WAY;
    localparam int TAG_BITS = `CDB_BITS;
    localparam int XLEN     = 32;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [XLEN-1:0]     data;
    } CDB_PACKET;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [XLEN-1:0]     data;
    } FU_RESULT_REQ;

endpackage

// File: rtl/cdb_arbiter_rr_select_n.sv
// Rotating-priority picker: grants the first K set bits of req_i scanning from ptr_i, modulo N.
module rr_select_n #(
    parameter int N  = 4,
    parameter int K  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [K*PW-1:0] slot_idx_o,
    output logic [K-1:0]    slot_vld_o,
    output logic [PW-1:0]   last_idx_o
);

    int idx;
    int cnt;

    always_comb begin
        gnt_o      = '0;
        slot_idx_o = '0;
        slot_vld_o = '0;
        last_idx_o = '0;
        idx        = 0;
        cnt        = 0;
        for (int off = 0; off < N; off++) begin
            // explicit wrap keeps the scan correct for non-power-of-two N
            idx = int'(ptr_i) + off;
            if (idx >= N) idx = idx - N;
            if (req_i[idx] && cnt < K) begin
                gnt_o[idx]                = 1'b1;
                slot_idx_o[cnt*PW +: PW]  = PW'(idx);
                slot_vld_o[cnt]           = 1'b1;
                last_idx_o                = PW'(idx);
                cnt                       = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant of up to N_CDB completions per cycle, registered onto the CDB.
module cdb_arbiter #(
    parameter int N_REQ    = 4,
    parameter int N_CDB    = cdb_arbiter_pkg::N_CDB,
    parameter int TAG_BITS = cdb_arbiter_pkg::TAG_BITS,
    parameter int XLEN     = cdb_arbiter_pkg::XLEN
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*TAG_BITS-1:0] req_tag,
    input  logic [N_REQ*XLEN-1:0]     req_data,
    input  logic                      flush,
    output logic [N_REQ-1:0]          grant,
    output logic [N_CDB-1:0]          cdb_valid,
    output logic [N_CDB*TAG_BITS-1:0] cdb_tag,
    output logic [N_CDB*XLEN-1:0]     cdb_data,
    output logic [$clog2(N_CDB):0]    cdb_count
);

    import cdb_arbiter_pkg::*;

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(N_CDB) + 1;

    logic [N_REQ-1:0]    eff;
    logic [N_REQ-1:0]    drain;
    logic [N_REQ-1:0]    sel_gnt;
    logic [N_CDB*PW-1:0] slot_idx;
    logic [N_CDB-1:0]    slot_vld;
    logic [PW-1:0]       last_idx;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    CDB_PACKET           slot_q [N_CDB];
    CDB_PACKET           slot_d [N_CDB];
    int                  sidx;

    // tag-0 results are granted only to let the source drain; they never reach the bus
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eff[i]   = req_valid[i] && (|req_tag[i*TAG_BITS +: TAG_BITS]) && !flush;
            drain[i] = req_valid[i] && !(|req_tag[i*TAG_BITS +: TAG_BITS]) && !flush;
        end
    end

    rr_select_n #(
        .N  (N_REQ),
        .K  (N_CDB),
        .PW (PW)
    ) u_sel (
        .req_i      (eff),
        .ptr_i      (rr_ptr_q),
        .gnt_o      (sel_gnt),
        .slot_idx_o (slot_idx),
        .slot_vld_o (slot_vld),
        .last_idx_o (last_idx)
    );

    assign grant = reset ? '0 : (sel_gnt | drain);

    always_comb begin
        count_d  = '0;
        rr_ptr_d = rr_ptr_q;
        sidx     = 0;
        for (int s = 0; s < N_CDB; s++) begin
            slot_d[s] = '0;
            if (slot_vld[s]) begin
                sidx           = int'(slot_idx[s*PW +: PW]);
                slot_d[s].valid = 1'b1;
                slot_d[s].tag   = req_tag[sidx*TAG_BITS +: TAG_BITS];
                slot_d[s].data  = req_data[sidx*XLEN +: XLEN];
                count_d         = count_d + CW'(1);
            end
        end
        if (|slot_vld) begin
            rr_ptr_d = (int'(last_idx) == N_REQ - 1) ? '0 : last_idx + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= '0;
            count_q  <= '0;
            for (int s = 0; s < N_CDB; s++) slot_q[s] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            for (int s = 0; s < N_CDB; s++) slot_q[s] <= slot_d[s];
        end
    end

    always_comb begin
        for (int s = 0; s < N_CDB; s++) begin
            cdb_valid[s]                      = slot_q[s].valid;
            cdb_tag[s*TAG_BITS +: TAG_BITS]   = slot_q[s].tag;
            cdb_data[s*XLEN +: XLEN]          = slot_q[s].data;
        end
    end

    assign cdb_count = count_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed plan cases followed by randomized traffic with flush and reset.
module tb_cdb_arbiter;

    logic         clock;
    logic         reset;
    logic [3:0]   req_valid;
    logic [23:0]  req_tag;
    logic [127:0] req_data;
    logic         flush;
    logic [3:0]   grant;
    logic [1:0]   cdb_valid;
    logic [11:0]  cdb_tag;
    logic [63:0]  cdb_data;
    logic [1:0]   cdb_count;

    cdb_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .flush     (flush),
        .grant     (grant),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_count (cdb_count)
    );

    typedef struct {
        logic [1:0]  v;
        logic [11:0] t;
        logic [63:0] d;
        logic [1:0]  c;
    } exp_t;

    exp_t exp_q[$];
    int   m_ptr = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Reference: effective requests in rotating order from m_ptr, first two win.
    task automatic drive(input logic [3:0] v, input logic [23:0] tg, input logic [127:0] dt,
                         input logic fl, input logic rs, output logic [3:0] g_exp);
        exp_t e;
        int   win[$];
        int   idx;
        @(negedge clock);
        req_valid = v;
        req_tag   = tg;
        req_data  = dt;
        flush     = fl;
        reset     = rs;
        e.v = '0; e.t = '0; e.d = '0; e.c = '0;
        g_exp = '0;
        if (!rs && !fl) begin
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (v[idx]) begin
                    if (tg[idx*6 +: 6] == 6'd0) g_exp[idx] = 1'b1;
                    else if (win.size() < 2) begin
                        win.push_back(idx);
                        g_exp[idx] = 1'b1;
                    end
                end
            end
            for (int s = 0; s < win.size(); s++) begin
                e.v[s]         = 1'b1;
                e.t[s*6 +: 6]  = tg[win[s]*6 +: 6];
                e.d[s*32 +: 32] = dt[win[s]*32 +: 32];
            end
            e.c = 2'(win.size());
            if (win.size() > 0) m_ptr = (win[win.size()-1] + 1) % 4;
        end
        if (rs) m_ptr = 0;
        #1;
        check("grant", 64'(grant), 64'(g_exp));
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cdb_valid", 64'(cdb_valid), 64'(e.v));
                check("cdb_tag",   64'(cdb_tag),   64'(e.t));
                check("cdb_data",  cdb_data,       e.d);
                check("cdb_count", 64'(cdb_count), 64'(e.c));
            end
        end
    end

    initial begin
        logic [3:0]   g;
        logic [3:0]   pv;
        logic [23:0]  pt;
        logic [127:0] pd;
        logic [127:0] rd;
        logic         fl, rs;

        reset = 1'b1; flush = 1'b0; req_valid = '0; req_tag = '0; req_data = '0;
        rd = {$urandom, $urandom, $urandom, $urandom};

        drive(4'b0000, 24'd0, 128'd0, 1'b0, 1'b1, g);
        drive(4'b0000, 24'd0, 128'd0, 1'b0, 1'b0, g);
        drive(4'b0000, 24'd0, 128'd0, 1'b0, 1'b0, g);

        drive(4'b0101, {6'd0, 6'd9, 6'd0, 6'd5}, rd, 1'b0, 1'b0, g);
        drive(4'b0000, 24'd0, rd, 1'b0, 1'b0, g);

        drive(4'b0000, 24'd0, 128'd0, 1'b0, 1'b1, g);
        for (int c = 0; c < 4; c++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            drive(4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, rd, 1'b0, 1'b0, g);
        end

        drive(4'b0100, {6'd0, 6'd7, 6'd0, 6'd0}, rd, 1'b0, 1'b0, g);
        drive(4'b1001, {6'd10, 6'd0, 6'd0, 6'd11}, rd, 1'b0, 1'b0, g);
        drive(4'b0010, 24'd0, rd, 1'b0, 1'b0, g);
        drive(4'b0001, {6'd0, 6'd0, 6'd0, 6'd12}, rd, 1'b0, 1'b0, g);
        drive(4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, rd, 1'b1, 1'b0, g);
        drive(4'b0000, 24'd0, rd, 1'b0, 1'b0, g);

        pv = '0; pt = '0; pd = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pv[i] && ($urandom % 3) != 0) begin
                    pv[i]          = 1'b1;
                    pt[i*6 +: 6]   = (($urandom % 6) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
                    pd[i*32 +: 32] = $urandom;
                end
            end
            fl = (($urandom % 16) == 0);
            rs = (($urandom % 60) == 0);
            drive(pv, pt, pd, fl, rs, g);
            pv = pv & ~g;
        end

        drive(4'b0000, 24'd0, 128'd0, 1'b0, 1'b0, g);
        drive(4'b0000, 24'd0, 128'd0, 1'b0, 1'b0, g);
        repeat (3) @(posedge clock);
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
